// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs MIPS-subset operations into words and streams them to IM
// Optional checksum output: define INSTR_ENCODER_LOADER_CHECKSUM_EN
module instr_encoder_loader #(
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              last,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
`ifdef INSTR_ENCODER_LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [31:0]       enc;
  logic              legal;
  logic              accept;
  logic [ADDR_W:0]   count_next;

  // Status and flow control are decoded straight from the registered state
  assign in_ready   = (state == S_LOAD) && (count < DEPTH_C);
  assign busy       = (state == S_LOAD);
  assign done       = (state == S_DONE);
  assign accept     = in_valid && in_ready;
  assign count_next = count + 1'b1;

  // Field packing for each operation class; ops 12-15 are flagged illegal
  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (op)
      4'd0:    enc = 32'h0;
      4'd1:    enc = {6'h00, rs, rt, rd, 5'h00, 6'h20};
      4'd2:    enc = {6'h00, rs, rt, rd, 5'h00, 6'h22};
      4'd3:    enc = {6'h0D, rs, rt, imm};
      4'd4:    enc = {6'h0F, 5'h00, rt, imm};
      4'd5:    enc = {6'h23, rs, rt, imm};
      4'd6:    enc = {6'h2B, rs, rt, imm};
      4'd7:    enc = {6'h04, rs, rt, imm};
      4'd8:    enc = {6'h02, target};
      4'd9:    enc = {6'h03, target};
      4'd10:   enc = {6'h00, rs, 15'h0000, 6'h08};
      4'd11:   enc = {6'h00, rs, 5'h00, rd, 5'h00, 6'h09};
      default: legal = 1'b0;
    endcase
  end

  // Load FSM: write pulse trails the accept by one cycle, count advances at the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      im_we    <= 1'b0;
      im_addr  <= 32'h0;
      im_wdata <= 32'h0;
      count    <= '0;
      err      <= 1'b0;
`ifdef INSTR_ENCODER_LOADER_CHECKSUM_EN
      checksum <= 32'h0;
`endif
    end else begin
      im_we <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (!legal) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              im_we    <= 1'b1;
              im_addr  <= BASE_ADDR + (32'(count) << 2);
              im_wdata <= enc;
              count    <= count_next;
`ifdef INSTR_ENCODER_LOADER_CHECKSUM_EN
              checksum <= checksum ^ enc;
`endif
              if (last) begin
                state <= S_DONE;
              end else if (count_next == DEPTH_C) begin
                state <= S_ERR;
                err   <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state <= S_LOAD;
            count <= '0;
            err   <= 1'b0;
`ifdef INSTR_ENCODER_LOADER_CHECKSUM_EN
            checksum <= 32'h0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder-side counterpart to the MIPS-subset instruction decode: packs operation-class plus operand fields into 32-bit MIPS instruction words.
- Streams the words into instruction memory at consecutive word addresses.
- Sits between the testbench/boot host and IM, so programs load without a hex file.
- Supported set: nop, add, sub, ori, lui, lw, sw, beq, j, jal, jr, jalr.

Parameters:
DEPTH, 1024, max words per program (power of two).
ADDR_W, 10, log2(DEPTH).
BASE_ADDR, 32'h0000_3000, byte address of the first word.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  begin a new program load.
in_valid  in  1  an encode request is present.
in_ready  out  1  the block can accept a request.
op  in  4  0 NOP, 1 ADD, 2 SUB, 3 ORI, 4 LUI, 5 LW, 6 SW, 7 BEQ, 8 J, 9 JAL, 10 JR, 11 JALR; 12-15 illegal.
rs, rt, rd  in  5 each  register fields.
imm  in  16  immediate or branch offset, raw.
target  in  26  jump index, raw.
last  in  1  final instruction of the program.
im_we  out  1  instruction-memory write strobe.
im_addr  out  32  byte address of the write.
im_wdata  out  32  encoded instruction word.
count  out  ADDR_W+1  words accepted since start.
busy  out  1  high in LOAD.
done  out  1  high in DONE.
err  out  1  sticky error flag.

Behaviour:
- Reset: state IDLE; in_ready, im_we, busy, done, err all 0; im_addr, im_wdata, count all 0. Reset dominates start and in_valid.
- States:
  - IDLE: start -> LOAD.
  - LOAD: accepts requests (transitions below).
  - DONE: start -> LOAD.
  - ERR: start -> LOAD.
- On entering LOAD from any state: count=0, err=0. start is ignored while in LOAD.
- In LOAD, in_ready = (count < DEPTH); it is combinational from state and count. A request is accepted when in_valid && in_ready; back-to-back accepts every cycle are allowed.
- Latency is 1 cycle. For a request accepted at edge N:
  - During cycle N+1: im_we=1, im_addr = BASE_ADDR + {count_at_accept, 2'b00} (32-bit wraparound), im_wdata = encoding.
  - count increments at edge N.
  - im_we is 0 in every cycle without a preceding accept.
- Encodings (fields not listed are 0):
  - ADD: {6'h00, rs, rt, rd, 5'h00, 6'h20}.
  - SUB: as ADD with funct 6'h22.
  - ORI: {6'h0D, rs, rt, imm}.
  - LUI: {6'h0F, 5'h00, rt, imm}; rs is ignored.
  - LW: {6'h23, rs, rt, imm}.
  - SW: {6'h2B, rs, rt, imm}.
  - BEQ: {6'h04, rs, rt, imm}.
  - J: {6'h02, target}.
  - JAL: {6'h03, target}.
  - JR: {6'h00, rs, 15'h0, 6'h08}.
  - JALR: {6'h00, rs, 5'h00, rd, 5'h00, 6'h09}.
  - NOP: 32'h0.
- Accepted with last=1 -> DONE at the same edge. The final write still pulses next cycle, and done rises together with it.
- Illegal op accepted: no write, count unchanged, err=1, state ERR, in_ready drops next cycle. last on that beat is ignored.
- Overflow: if count reaches DEPTH in LOAD without a last beat, state goes to ERR with err=1. The final (DEPTH-th) write still completes.
- Reset mid-load: any pending im_we is cancelled the next cycle and all outputs return to reset values.

Optional Feature:
- Macro: INSTR_ENCODER_LOADER_CHECKSUM_EN.
- Defined: adds output checksum [31:0]. It is cleared on reset and on start, and XOR-accumulates every im_wdata written (on im_we cycles), so it is final when done rises.
- Undefined: no checksum port and no accumulator logic. All other behaviour is identical.

Test Plan:
- Reset then start; ADD rs=1 rt=2 rd=3 last=1 -> next cycle im_we=1, im_addr=32'h3000, im_wdata=32'h00221820, done=1, count=1.
- Back-to-back ORI rs=0 rt=8 imm=16'h1234, then LW rs=29 rt=9 imm=16'hFFFC last=1 -> writes 32'h34081234 @32'h3000 and 32'h8FA9FFFC @32'h3004 on consecutive cycles; in_ready never drops before last.
- JAL target=26'h0000C00, then JR rs=31 last=1 -> 32'h0C000C00 and 32'h03E00008; LUI rs=7 rt=1 imm=16'hABCD -> 32'h3C01ABCD (rs ignored).
- Illegal op=14 after two valid beats -> no third write, err=1, in_ready=0, count=2; a later start clears err and restarts at 32'h3000.
- DEPTH=4 with 4 NOPs and no last -> 4 writes up to 32'h300C, then ERR, err=1, in_ready=0; a 5th in_valid is never accepted.
- reset asserted in the cycle after an accept, with start held high -> im_we=0 and all outputs 0 the following cycle; state IDLE, not LOAD.
